// File: rtl/flag_unit.sv
// flag_unit: execute-stage flag register, branch-condition evaluator and
// one-cycle redirect pulse generator for the fetch stage.
module flag_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] alu_flag,
    input  logic [2:0] flag_we,
    input  logic       ex_valid,
    input  logic       stall,
    input  logic       flush,
    input  logic       br_eval,
    input  logic [2:0] br_cond,
    output logic [2:0] flag_q,
    output logic       br_taken,
    output logic       br_redirect
);

    // Bit positions of Z, V and N inside every 3-bit flag vector.
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Branch condition codes, evaluated against the effective flags.
    typedef enum logic [2:0] {
        COND_NEQ    = 3'b000,
        COND_EQ     = 3'b001,
        COND_GT     = 3'b010,
        COND_LT     = 3'b011,
        COND_GTE    = 3'b100,
        COND_LTE    = 3'b101,
        COND_OVFL   = 3'b110,
        COND_UNCOND = 3'b111
    } cond_e;

    // Redirect FSM: FIRE lasts one cycle per committed taken branch.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FIRE = 1'b1
    } state_e;

    logic [2:0] r_flag;
    state_e     r_state;
    state_e     w_state_nxt;
    logic       w_upd;
    logic       w_byp;
    logic [2:0] w_wr_mask;
    logic [2:0] w_byp_mask;
    logic [2:0] w_eff;
    logic       w_taken;
    logic       w_commit;

    // Evaluate one condition code against a Z/V/N flag vector.
    function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
        logic z;
        logic v;
        logic n;
        logic res;
        z   = flags[FLAG_Z];
        v   = flags[FLAG_V];
        n   = flags[FLAG_N];
        res = 1'b0;
        case (cond_e'(cond))
            COND_NEQ:    res = ~z;
            COND_EQ:     res = z;
            COND_GT:     res = ~z & ~n;
            COND_LT:     res = n;
            COND_GTE:    res = z | (~z & ~n);
            COND_LTE:    res = z | n;
            COND_OVFL:   res = v;
            COND_UNCOND: res = 1'b1;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

    // An instruction commits its flags only when real, not held and not squashed.
    assign w_upd     = ex_valid & ~stall & ~flush;
    assign w_wr_mask = {3{w_upd}} & flag_we;

    // The bypass deliberately ignores stall: a held writer is still older
    // than the branch, so its result is what the branch must see.
    assign w_byp      = ex_valid & ~flush;
    assign w_byp_mask = {3{w_byp}} & flag_we;
    assign w_eff      = (w_byp_mask & alu_flag) | (~w_byp_mask & r_flag);

    assign w_taken  = br_eval & cond_true(br_cond, w_eff);
    assign w_commit = w_taken & ~stall & ~flush;

    // Architectural flag register: each enabled bit takes the ALU value, others hold.
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order; async reset is in the
    // sensitivity list so it acts without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= 3'b000;
        end else begin
            r_flag <= (w_wr_mask & alu_flag) | (~w_wr_mask & r_flag);
        end
    end

    // Redirect FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Redirect FSM next state: flush beats stall, stall freezes, a committed
    // taken branch (re)enters FIRE, otherwise FIRE drops back to IDLE.
    always_comb begin
        // NOTE: default assigned first so no path leaves the signal unassigned
        // and no latch is inferred.
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else if (stall) begin
            w_state_nxt = r_state;
        end else if (w_commit) begin
            w_state_nxt = ST_FIRE;
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign flag_q      = r_flag;
    assign br_taken    = w_taken;
    assign br_redirect = (r_state == ST_FIRE);

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed self-checking bench for flag_unit.
module tb_flag_unit;

    localparam int FZ = 2;
    localparam int FV = 1;
    localparam int FN = 0;

    logic       clk;
    logic       rst;
    logic [2:0] alu_flag;
    logic [2:0] flag_we;
    logic       ex_valid;
    logic       stall;
    logic       flush;
    logic       br_eval;
    logic [2:0] br_cond;
    logic [2:0] flag_q;
    logic       br_taken;
    logic       br_redirect;

    int checks;
    int failures;

    flag_unit dut (
        .clk         (clk),
        .rst         (rst),
        .alu_flag    (alu_flag),
        .flag_we     (flag_we),
        .ex_valid    (ex_valid),
        .stall       (stall),
        .flush       (flush),
        .br_eval     (br_eval),
        .br_cond     (br_cond),
        .flag_q      (flag_q),
        .br_taken    (br_taken),
        .br_redirect (br_redirect)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Build a flag vector from individual Z, V, N values.
    function automatic logic [2:0] mk(input logic z, input logic v, input logic n);
        logic [2:0] f;
        f     = 3'b000;
        f[FZ] = z;
        f[FV] = v;
        f[FN] = n;
        return f;
    endfunction

    // Expected branch outcome written directly from the condition table.
    function automatic logic exp_cond(input int c, input logic [2:0] f);
        logic z;
        logic v;
        logic n;
        z = f[FZ];
        v = f[FV];
        n = f[FN];
        if (c == 0) return !z;
        if (c == 1) return z;
        if (c == 2) return !z && !n;
        if (c == 3) return n;
        if (c == 4) return z || !n;
        if (c == 5) return z || n;
        if (c == 6) return v;
        return 1'b1;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_flag = 3'b000;
        flag_we  = 3'b000;
        ex_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        br_eval  = 1'b0;
        br_cond  = 3'b000;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        chk3("reset_flag_q", flag_q, 3'b000);
        chk1("reset_redirect", br_redirect, 1'b0);
        br_eval = 1'b1;
        br_cond = 3'b000;
        #1;
        chk1("reset_taken_neq", br_taken, 1'b1);
        br_cond = 3'b001;
        #1;
        chk1("reset_taken_eq", br_taken, 1'b0);
        br_eval = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        // Load all flags and arm a redirect, then reset mid-cycle.
        ex_valid = 1'b1;
        alu_flag = 3'b111;
        flag_we  = 3'b111;
        br_eval  = 1'b1;
        br_cond  = 3'b111;
        tick();
        idle_inputs();
        chk3("pre_reset_flag_q", flag_q, 3'b111);
        chk1("pre_reset_redirect", br_redirect, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk3("midcycle_reset_flag_q", flag_q, 3'b000);
        chk1("midcycle_reset_redirect", br_redirect, 1'b0);
        #1;
        rst = 1'b0;
        tick();
        chk3("post_reset_flag_q", flag_q, 3'b000);
        chk1("post_reset_redirect", br_redirect, 1'b0);
    endtask

    task automatic test_partial_update();
        ex_valid = 1'b1;
        alu_flag = mk(1, 1, 1);
        flag_we  = 3'b111;
        tick();
        chk3("full_update", flag_q, mk(1, 1, 1));
        // Shift result: only Z is written.
        alu_flag = mk(0, 0, 0);
        flag_we  = mk(1, 0, 0);
        tick();
        chk3("partial_update_z", flag_q, mk(0, 1, 1));
        // A writer with no enables changes neither flag_q nor the bypass.
        alu_flag = mk(1, 0, 0);
        flag_we  = 3'b000;
        br_eval  = 1'b1;
        br_cond  = 3'b001;
        #1;
        chk1("we0_no_bypass", br_taken, 1'b0);
        br_eval = 1'b0;
        tick();
        chk3("we0_no_update", flag_q, mk(0, 1, 1));
        chk1("we0_no_redirect", br_redirect, 1'b0);
        idle_inputs();
    endtask

    task automatic test_bypass();
        // flag_q has Z=0; SUB in execute writes Z=1 while an EQ branch resolves.
        ex_valid = 1'b1;
        alu_flag = mk(1, 0, 0);
        flag_we  = 3'b111;
        br_eval  = 1'b1;
        br_cond  = 3'b001;
        #1;
        chk1("bypass_taken", br_taken, 1'b1);
        chk1("bypass_redirect_not_yet", br_redirect, 1'b0);
        tick();
        idle_inputs();
        chk1("bypass_redirect", br_redirect, 1'b1);
        chk3("bypass_flag_q", flag_q, mk(1, 0, 0));
        tick();
        chk1("bypass_redirect_one_cycle", br_redirect, 1'b0);
    endtask

    task automatic test_stall();
        ex_valid = 1'b1;
        alu_flag = 3'b000;
        flag_we  = 3'b111;
        tick();
        chk3("stall_setup", flag_q, 3'b000);
        stall    = 1'b1;
        alu_flag = mk(1, 0, 0);
        br_eval  = 1'b1;
        br_cond  = 3'b001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("stall_taken_bypass", br_taken, 1'b1);
            tick();
            chk3("stall_flag_hold", flag_q, 3'b000);
            chk1("stall_no_redirect", br_redirect, 1'b0);
        end
        stall = 1'b0;
        tick();
        idle_inputs();
        chk3("stall_release_update", flag_q, mk(1, 0, 0));
        chk1("stall_release_redirect", br_redirect, 1'b1);
        tick();
        chk1("stall_release_redirect_drop", br_redirect, 1'b0);
    endtask

    task automatic test_back_to_back();
        br_eval = 1'b1;
        br_cond = 3'b111;
        tick();
        chk1("b2b_first", br_redirect, 1'b1);
        tick();
        chk1("b2b_second", br_redirect, 1'b1);
        // Stall while in FIRE freezes the state.
        br_eval = 1'b0;
        stall   = 1'b1;
        tick();
        chk1("fire_stall_hold", br_redirect, 1'b1);
        stall = 1'b0;
        tick();
        chk1("b2b_drop", br_redirect, 1'b0);
        idle_inputs();
    endtask

    task automatic test_flush();
        // flag_q is Z=1 here.
        flush    = 1'b1;
        ex_valid = 1'b1;
        alu_flag = mk(0, 1, 1);
        flag_we  = 3'b111;
        br_eval  = 1'b1;
        br_cond  = 3'b111;
        #1;
        chk1("flush_taken_comb", br_taken, 1'b1);
        // A squashed writer is not bypassed: EQ sees flag_q Z=1.
        br_cond = 3'b001;
        #1;
        chk1("flush_no_bypass", br_taken, 1'b1);
        br_cond = 3'b111;
        tick();
        chk1("flush_no_redirect", br_redirect, 1'b0);
        chk3("flush_flag_hold", flag_q, mk(1, 0, 0));
        // Flush cancels a pending redirect.
        idle_inputs();
        br_eval = 1'b1;
        br_cond = 3'b111;
        tick();
        chk1("flush_prearm", br_redirect, 1'b1);
        flush = 1'b1;
        tick();
        chk1("flush_cancels_fire", br_redirect, 1'b0);
        idle_inputs();
        tick();
    endtask

    task automatic test_cond_sweep();
        for (int f = 0; f < 8; f++) begin
            idle_inputs();
            ex_valid = 1'b1;
            flag_we  = 3'b111;
            alu_flag = 3'(f);
            tick();
            idle_inputs();
            chk3("sweep_load", flag_q, 3'(f));
            for (int c = 0; c < 8; c++) begin
                br_eval = 1'b1;
                br_cond = 3'(c);
                #1;
                chk1($sformatf("cond%0d_flags%0d", c, f), br_taken, exp_cond(c, 3'(f)));
            end
            br_eval = 1'b0;
            br_cond = 3'b111;
            #1;
            chk1("sweep_eval0", br_taken, 1'b0);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle_inputs();
        test_reset();
        test_partial_update();
        test_bypass();
        test_stall();
        test_back_to_back();
        test_flush();
        test_cond_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
